// File: rtl/fpu_dispatch_pkg.sv
// Shared definitions for the FPU arithmetic dispatch stage: op codes, flag/cc bit
// positions and the dispatch FSM encoding.
package fpu_dispatch_pkg;

  localparam logic [3:0] OP_ADD      = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_MUL      = 4'd2;
  localparam logic [3:0] OP_DIV      = 4'd3;
  localparam logic [3:0] OP_I16_TO_F = 4'd4;
  localparam logic [3:0] OP_I32_TO_F = 4'd5;
  localparam logic [3:0] OP_F_TO_I16 = 4'd6;
  localparam logic [3:0] OP_F_TO_I32 = 4'd7;
  localparam logic [3:0] OP_F32_TO_F = 4'd8;
  localparam logic [3:0] OP_F64_TO_F = 4'd9;
  localparam logic [3:0] OP_F_TO_F32 = 4'd10;
  localparam logic [3:0] OP_F_TO_F64 = 4'd11;
  localparam logic [3:0] OP_SQRT     = 4'd12;
  localparam logic [3:0] OP_SIN      = 4'd13;
  localparam logic [3:0] OP_COS      = 4'd14;
  localparam logic [3:0] OP_SINCOS   = 4'd15;

  localparam int FLG_INVALID     = 0;
  localparam int FLG_DENORMAL    = 1;
  localparam int FLG_ZERO_DIVIDE = 2;
  localparam int FLG_OVERFLOW    = 3;
  localparam int FLG_UNDERFLOW   = 4;
  localparam int FLG_INEXACT     = 5;

  localparam int CC_LESS      = 0;
  localparam int CC_EQUAL     = 1;
  localparam int CC_GREATER   = 2;
  localparam int CC_UNORDERED = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fpu_dispatch_watchdog.sv
// Cycle counter for an in-flight FPU op; expire_o pulses on the last allowed
// cycle while run_i is high. Instantiated only when FPU_DISPATCH_TIMEOUT_EN is set.
module fpu_dispatch_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = run_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fpu_arith_dispatch.sv
// Issue stage in front of the FPU arithmetic unit: one op in flight, response
// buffered until taken, sticky exception status. Optional watchdog: FPU_DISPATCH_TIMEOUT_EN.
module fpu_arith_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [1:0]  req_rmode,
  input  logic [79:0] req_a,
  input  logic [79:0] req_b,
  input  logic [31:0] req_int,
  input  logic [63:0] req_fpn,
  output logic [3:0]  au_operation,
  output logic        au_enable,
  output logic [1:0]  au_rmode,
  output logic [79:0] au_a,
  output logic [79:0] au_b,
  output logic [15:0] au_int16,
  output logic [31:0] au_int32,
  output logic [31:0] au_fp32,
  output logic [63:0] au_fp64,
  input  logic [79:0] au_result,
  input  logic [15:0] au_int16_out,
  input  logic [31:0] au_int32_out,
  input  logic [31:0] au_fp32_out,
  input  logic [63:0] au_fp64_out,
  input  logic        au_done,
  input  logic [3:0]  au_cc,
  input  logic [5:0]  au_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [79:0] rsp_result,
  output logic [31:0] rsp_int,
  output logic [63:0] rsp_fpn,
  output logic [3:0]  rsp_cc,
  output logic [5:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic [5:0]  status_flags,
  input  logic        clear_flags,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready and the payload holds while valid is up.

  localparam logic [5:0] TIMEOUT_FLAGS = 6'(1 << FLG_INVALID);

  state_e state_q, state_d;

  logic [3:0]  op_q;
  logic [1:0]  rmode_q;
  logic [79:0] a_q, b_q;
  logic [31:0] int_q;
  logic [63:0] fpn_q;

  logic [79:0] res_q;
  logic [31:0] rint_q;
  logic [63:0] rfpn_q;
  logic [3:0]  cc_q;
  logic [5:0]  flags_q;
  logic [5:0]  status_q, status_d;

  logic accept, active, expire, capture_done, capture_to;

  assign accept       = (state_q == ST_IDLE) && req_valid;
  assign active       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign capture_done = active && au_done;
  assign capture_to   = active && !au_done && expire;

`ifdef FPU_DISPATCH_TIMEOUT_EN
  logic tout_q;

  fpu_dispatch_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst      (reset),
    .start_i  (accept),
    .run_i    (active),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tout_q <= 1'b0;
    end else if (capture_done) begin
      tout_q <= 1'b0;
    end else if (capture_to) begin
      tout_q <= 1'b1;
    end
  end

  assign rsp_timeout = tout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expire      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (au_done || expire) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (au_done || expire) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear first, then OR in the capture so a simultaneous new op survives the clear.
  always_comb begin
    status_d = clear_flags ? 6'b0 : status_q;
    if (capture_done) begin
      status_d = status_d | au_flags;
    end else if (capture_to) begin
      status_d = status_d | TIMEOUT_FLAGS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      status_q <= 6'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      rmode_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      int_q   <= '0;
      fpn_q   <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      rmode_q <= req_rmode;
      a_q     <= req_a;
      b_q     <= req_b;
      int_q   <= req_int;
      fpn_q   <= req_fpn;
    end
  end

  // SINCOS secondary output is not captured here; only the primary result path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      rint_q  <= '0;
      rfpn_q  <= '0;
      cc_q    <= '0;
      flags_q <= '0;
    end else if (capture_done) begin
      res_q   <= au_result;
      rint_q  <= (op_q == OP_F_TO_I16) ? sext16(au_int16_out) : au_int32_out;
      rfpn_q  <= (op_q == OP_F_TO_F32) ? {32'b0, au_fp32_out} : au_fp64_out;
      cc_q    <= au_cc;
      flags_q <= au_flags;
    end else if (capture_to) begin
      res_q   <= '0;
      rint_q  <= '0;
      rfpn_q  <= '0;
      cc_q    <= '0;
      flags_q <= TIMEOUT_FLAGS;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign au_enable    = (state_q == ST_ISSUE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

  assign au_operation = op_q;
  assign au_rmode     = rmode_q;
  assign au_a         = a_q;
  assign au_b         = b_q;
  assign au_int16     = int_q[15:0];
  assign au_int32     = int_q;
  assign au_fp32      = fpn_q[31:0];
  assign au_fp64      = fpn_q;

  assign rsp_result   = res_q;
  assign rsp_int      = rint_q;
  assign rsp_fpn      = rfpn_q;
  assign rsp_cc       = cc_q;
  assign rsp_flags    = flags_q;
  assign status_flags = status_q;

endmodule

// File: tb/tb_fpu_arith_dispatch.sv
// Bench for fpu_arith_dispatch: table vectors, hand-written corner sequences and
// randomized ops checked against a response/status model.
module tb_fpu_arith_dispatch;
  import fpu_dispatch_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_rmode;
  logic [79:0] req_a, req_b;
  logic [31:0] req_int;
  logic [63:0] req_fpn;
  logic [3:0]  au_operation;
  logic        au_enable;
  logic [1:0]  au_rmode;
  logic [79:0] au_a, au_b;
  logic [15:0] au_int16;
  logic [31:0] au_int32, au_fp32;
  logic [63:0] au_fp64;
  logic [79:0] au_result;
  logic [15:0] au_int16_out;
  logic [31:0] au_int32_out, au_fp32_out;
  logic [63:0] au_fp64_out;
  logic        au_done;
  logic [3:0]  au_cc;
  logic [5:0]  au_flags;
  logic        rsp_valid, rsp_ready;
  logic [79:0] rsp_result;
  logic [31:0] rsp_int;
  logic [63:0] rsp_fpn;
  logic [3:0]  rsp_cc;
  logic [5:0]  rsp_flags;
  logic        rsp_timeout;
  logic [5:0]  status_flags;
  logic        clear_flags;
  logic        busy;
  logic [1:0]  dbg_state;

  fpu_arith_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rmode(req_rmode),
    .req_a(req_a), .req_b(req_b), .req_int(req_int), .req_fpn(req_fpn),
    .au_operation(au_operation), .au_enable(au_enable), .au_rmode(au_rmode),
    .au_a(au_a), .au_b(au_b), .au_int16(au_int16), .au_int32(au_int32),
    .au_fp32(au_fp32), .au_fp64(au_fp64),
    .au_result(au_result), .au_int16_out(au_int16_out), .au_int32_out(au_int32_out),
    .au_fp32_out(au_fp32_out), .au_fp64_out(au_fp64_out), .au_done(au_done),
    .au_cc(au_cc), .au_flags(au_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_int(rsp_int), .rsp_fpn(rsp_fpn), .rsp_cc(rsp_cc), .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout), .status_flags(status_flags), .clear_flags(clear_flags),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [79:0] a, b;
    logic [79:0] res;
    logic [15:0] i16o;
    logic [31:0] i32o, f32o;
    logic [63:0] f64o;
    logic [3:0]  cc;
    logic [5:0]  flags;
    int          done_dly;
    int          rsp_wait;
    logic [79:0] exp_res;
    logic [31:0] exp_int;
    logic [63:0] exp_fpn;
  } vec_t;

  typedef struct {
    logic [79:0] res;
    logic [31:0] iv;
    logic [63:0] fv;
    logic [3:0]  cc;
    logic [5:0]  flags;
    logic        tout;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] status_model;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic [3:0] op, input logic [79:0] a, input logic [79:0] b,
                               input logic [79:0] res, input logic [15:0] i16o,
                               input logic [31:0] i32o, input logic [31:0] f32o,
                               input logic [63:0] f64o, input logic [3:0] cc,
                               input logic [5:0] flags, input int dly, input int wt,
                               input logic [79:0] er, input logic [31:0] ei,
                               input logic [63:0] ef);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.i16o = i16o; v.i32o = i32o;
    v.f32o = f32o; v.f64o = f64o; v.cc = cc; v.flags = flags; v.done_dly = dly;
    v.rsp_wait = wt; v.exp_res = er; v.exp_int = ei; v.exp_fpn = ef;
    return v;
  endfunction

  function automatic exp_t from_table(input vec_t v);
    exp_t e;
    e.res = v.exp_res; e.iv = v.exp_int; e.fv = v.exp_fpn; e.cc = v.cc;
    e.flags = v.flags; e.tout = 1'b0; e.lat = v.done_dly;
    return e;
  endfunction

  // Reference model: what the response port should carry for a given unit behaviour.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    bit   wd_on;
    int   s;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    wd_on = 1'b1;
`else
    wd_on = 1'b0;
`endif
    if (wd_on && (v.done_dly < 0 || v.done_dly > TO - 1)) begin
      e.res = '0; e.iv = '0; e.fv = '0; e.cc = '0;
      e.flags = 6'b000001; e.tout = 1'b1; e.lat = TO - 1;
    end else begin
      e.res = v.res;
      if (v.op == 4'd6) begin
        s = int'(v.i16o);
        if (s >= 32768) s = s - 65536;
        e.iv = 32'(s);
      end else begin
        e.iv = v.i32o;
      end
      e.fv = (v.op == 4'd10) ? 64'(v.f32o) : v.f64o;
      e.cc = v.cc; e.flags = v.flags; e.tout = 1'b0; e.lat = v.done_dly;
    end
    return e;
  endfunction

  // Driver: issue one request, act as the arithmetic unit, then drain the response.
  task automatic run_op(input vec_t v, input exp_t e, input logic clr_at_done);
    int   k;
    logic got;
    exp_t ex;
    exp_q.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = v.op; req_rmode = 2'($urandom_range(0, 3));
    req_a = v.a; req_b = v.b;
    req_int = $urandom; req_fpn = {$urandom, $urandom};
    au_result = v.res; au_int16_out = v.i16o; au_int32_out = v.i32o;
    au_fp32_out = v.f32o; au_fp64_out = v.f64o; au_cc = v.cc; au_flags = v.flags;
    au_done = 1'b0;
    @(posedge clk);
    got = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      au_done = (k == v.done_dly);
      clear_flags = clr_at_done && (k == v.done_dly);
      chk("au_enable_pulse", au_enable, k == 0);
      chk("req_ready_busy", req_ready, 1'b0);
      chk("au_hold_op", au_operation, v.op);
      chk("au_hold_a", au_a, v.a);
      if (k == 0) begin
        chk("au_b", au_b, v.b);
        chk("au_int32", au_int32, req_int);
        chk("au_int16", au_int16, req_int[15:0]);
        chk("au_fp64", au_fp64, req_fpn);
        chk("au_fp32", au_fp32, req_fpn[31:0]);
        chk("au_rmode", au_rmode, req_rmode);
      end
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    au_done = 1'b0;
    clear_flags = 1'b0;
    chk("rsp_seen", got, 1'b1);
    ex = exp_q.pop_front();
    chk("latency", k, ex.lat);
    status_model = (clr_at_done ? 6'b0 : status_model) | ex.flags;
    for (int w = 0; w <= v.rsp_wait; w++) begin
      if (w == 0 || w == v.rsp_wait) begin
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_result", rsp_result, ex.res);
        chk("rsp_int", rsp_int, ex.iv);
        chk("rsp_fpn", rsp_fpn, ex.fv);
        chk("rsp_cc", rsp_cc, ex.cc);
        chk("rsp_flags", rsp_flags, ex.flags);
        chk("rsp_timeout", rsp_timeout, ex.tout);
        chk("req_ready_resp", req_ready, 1'b0);
        chk("status_flags", status_flags, status_model);
      end
      if (w < v.rsp_wait) begin
        req_valid = 1'b1;
        req_op = ~v.op;
        @(posedge clk);
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("busy_drop", busy, 1'b0);
    chk("no_early_accept", au_operation, v.op);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rmode = '0; req_a = '0; req_b = '0;
    req_int = '0; req_fpn = '0; au_result = '0; au_int16_out = '0; au_int32_out = '0;
    au_fp32_out = '0; au_fp64_out = '0; au_done = 1'b0; au_cc = '0; au_flags = '0;
    rsp_ready = 1'b0; clear_flags = 1'b0; status_model = '0;

    tbl[0] = mkv(4'd0, 80'h3FFF8000000000000000, 80'h40008000000000000000,
                 80'h4000C000000000000000, 16'h0, 32'h0, 32'h0, 64'h0, 4'b0000, 6'b0, 0, 0,
                 80'h4000C000000000000000, 32'h0, 64'h0);
    tbl[1] = mkv(4'd3, 80'h3FFF8000000000000000, 80'h0, 80'h7FFF8000000000000000,
                 16'h0, 32'h0, 32'h0, 64'h0, 4'b0100, 6'b000100, 5, 1,
                 80'h7FFF8000000000000000, 32'h0, 64'h0);
    tbl[2] = mkv(4'd2, 80'h4000C000000000000000, 80'h3FFF8000000000000000,
                 80'h4000C000000000000000, 16'h0, 32'h0, 32'h0, 64'h0, 4'b0100, 6'b0, 2, 0,
                 80'h4000C000000000000000, 32'h0, 64'h0);
    tbl[3] = mkv(4'd6, 80'h1, 80'h0, 80'h0, 16'hFFFE, 32'h12345678, 32'h0,
                 64'h1111, 4'b0001, 6'b100000, 1, 0, 80'h0, 32'hFFFFFFFE, 64'h1111);
    tbl[4] = mkv(4'd10, 80'h3FFF8000000000000000, 80'h0, 80'h0, 16'h0, 32'h7,
                 32'h3F800000, 64'hDEADBEEFCAFEF00D, 4'b0010, 6'b0, 0, 0,
                 80'h0, 32'h7, 64'h000000003F800000);
    tbl[5] = mkv(4'd0, 80'h12345, 80'h6789A, 80'hABCDEF, 16'h0, 32'h0, 32'h0,
                 64'h55, 4'b0000, 6'b001000, 3, 10, 80'hABCDEF, 32'h0, 64'h55);
    tbl[6] = mkv(4'd7, 80'h0, 80'h0, 80'h0, 16'h8000, 32'h80000000, 32'h0,
                 64'h0, 4'b1000, 6'b000001, 0, 0, 80'h0, 32'h80000000, 64'h0);
    tbl[7] = mkv(4'd6, 80'h0, 80'h0, 80'h0, 16'h7FFF, 32'hFFFFFFFF, 32'h0,
                 64'h0, 4'b0000, 6'b0, 1, 2, 80'h0, 32'h00007FFF, 64'h0);
    tbl[8] = mkv(4'd15, 80'h3FFE8000000000000000, 80'h0, 80'h3FFEB000000000000000,
                 16'h0, 32'h0, 32'h0, 64'h99, 4'b0010, 6'b100000, 2, 0,
                 80'h3FFEB000000000000000, 32'h0, 64'h99);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_au_enable", au_enable, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_au_a", au_a, 80'h0);
    chk("rst_rsp_result", rsp_result, 80'h0);
    chk("rst_status", status_flags, 6'b0);
    chk("rst_timeout", rsp_timeout, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i], from_table(tbl[i]), 1'b0);
      if (i == 2) chk("sticky_zero_divide", status_flags[FLG_ZERO_DIVIDE], 1'b1);
    end

    // Clear in idle, then clear coinciding with a capture: new op's flags survive.
    @(negedge clk);
    clear_flags = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_flags = 1'b0;
    status_model = 6'b0;
    chk("clear_idle", status_flags, 6'b0);
    run_op(tbl[1], from_table(tbl[1]), 1'b0);
    run_op(tbl[3], from_table(tbl[3]), 1'b1);
    chk("clear_vs_capture", status_flags, 6'b100000);

    // Reset while the unit is still working: op is dropped silently.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd12; req_a = 80'h777; au_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_wait", dbg_state, 2'd2);
    reset = 1'b1;
    #1;
    chk("rst_mid_enable", au_enable, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    status_model = 6'b0;
    au_done = 1'b1;
    @(negedge clk);
    au_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_phantom_rsp", rsp_valid, 1'b0);
    end
    chk("rst_mid_status", status_flags, 6'b0);
    run_op(tbl[0], from_table(tbl[0]), 1'b0);

`ifdef FPU_DISPATCH_TIMEOUT_EN
    rv = tbl[2]; rv.done_dly = -1;
    run_op(rv, model(rv), 1'b0);
    rv = tbl[4]; rv.done_dly = TO - 1;
    run_op(rv, model(rv), 1'b0);
`endif

    // Randomized ops against the model.
    for (int n = 0; n < 40; n++) begin
      rv.op = 4'($urandom_range(0, 15));
      rv.a = {16'($urandom), $urandom, $urandom};
      rv.b = {16'($urandom), $urandom, $urandom};
      rv.res = {16'($urandom), $urandom, $urandom};
      rv.i16o = 16'($urandom);
      rv.i32o = $urandom;
      rv.f32o = $urandom;
      rv.f64o = {$urandom, $urandom};
      rv.cc = 4'($urandom_range(0, 15));
      rv.flags = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'b0;
      rv.done_dly = $urandom_range(0, 4);
      rv.rsp_wait = $urandom_range(0, 3);
      run_op(rv, model(rv), $urandom_range(0, 7) == 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
